output_writer: RTL and testbench
================================

Name: output_writer

Overview:
- Stage directly downstream of the 16-lane output packer.
- Accepts packed 128-bit output words over a valid/ready handshake and buffers them in a small FIFO.
- Writes the words to consecutive addresses of the output SRAM through a request/grant write port, starting from a programmed base address.
- Signals completion once a programmed number of words has been written.

Parameters:
- MEM_BW, 128, packed word width; byte 0 occupies bits [MEM_BW-1:MEM_BW-8].
- ADDR_WIDTH, 16, output-memory word-address width.
- CNT_WIDTH, 16, width of the word-count registers.
- FIFO_DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- arst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches base_addr and num_words; honoured only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address.
- num_words  input  CNT_WIDTH  number of words in the job.
- in_data  input  MEM_BW  packed word from the packer.
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer accepts in_data this cycle.
- mem_we  output  1  write request.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  MEM_BW  write data.
- mem_gnt  input  1  memory accepts the request this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values, all outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0. Reset also empties the FIFO and zeroes all counters.
- Reset mid-job: the job is aborted and any buffered words are discarded.
- States:
  - IDLE: start=1 latches the job, clears the counters and moves to RUN. If num_words=0, it moves to DONE instead.
  - RUN: moves to DONE in the cycle after the grant of the final word (wr_cnt reaches num_words).
  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
  - start is ignored in RUN and DONE.
- Input side:
  - in_ready = RUN and fifo_not_full and acc_cnt < num_words.
  - A push happens when in_valid and in_ready are both high; acc_cnt then increments.
  - in_valid while in_ready=0 has no effect.
  - The full flag is evaluated before any same-cycle pop; a full FIFO does not accept, even while popping.
- Output side:
  - mem_we = RUN and fifo_not_empty. mem_wdata is the FIFO head; mem_addr = base_addr + wr_cnt.
  - On mem_we and mem_gnt: pop, wr_cnt increments, and mem_addr advances next cycle.
  - With mem_gnt=0, mem_we, mem_addr and mem_wdata hold stable.
- Latency: a word pushed in cycle t can appear on mem_we at the earliest in cycle t+1 (registered FIFO, no bypass).
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged, pointers advance independently.
- Address wrap: mem_addr wraps modulo 2^ADDR_WIDTH, with no error.
- Data is passed through unmodified; byte order is preserved.
- busy=1 only in RUN.

Optional Feature:
- Macro: OUTPUT_WRITER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [31:0].
  - Cleared on reset and on an accepted start.
  - Increments each RUN cycle with mem_we=1 and mem_gnt=0; saturates at 2^32-1.
  - Holds its value after DONE until the next start.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Basic job: reset, then start with base_addr=0x0100, num_words=4, in_valid held high, mem_gnt held high. Required:
  - Four writes to 0x0100..0x0103, with data matching the input order.
  - done pulses one cycle after the 4th grant; busy falls in the same cycle.
- Backpressure: num_words=8, mem_gnt=0 for 10 cycles, then 1. Required:
  - in_ready drops after exactly 4 accepts.
  - mem_addr and mem_wdata hold stable during the stall.
  - All 8 words are written in order; stall_cycles=10 when the macro is defined.
- Zero-length job: start with num_words=0. Required: done=1 in the next cycle; no mem_we; in_ready stays 0.
- Wrap and excess input: base_addr=0xFFFE, num_words=3, with in_valid high for 5 words. Required:
  - Writes go to 0xFFFE, 0xFFFF, 0x0000.
  - in_ready=0 after the 3rd accept.
- Reset mid-job: num_words=6, assert arst after 2 writes. Required:
  - All outputs return to 0 and no further mem_we.
  - A new start with base_addr=0x0010, num_words=1 writes exactly once to 0x0010.
- Start while busy: a second start during RUN is ignored. Required: the original base_addr and num_words complete unchanged.

Source files
------------

// File: rtl/output_writer.sv
// Output writer: buffers packed words from the packer and streams them to consecutive SRAM addresses.
// Optional macro OUTPUT_WRITER_STALL_CNT_EN adds a stall_cycles counter of cycles spent waiting on mem_gnt.
module output_writer #(
  parameter int MEM_BW     = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [MEM_BW-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_BW-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  output logic                  busy,
  output logic                  done
`ifdef OUTPUT_WRITER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]       OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]       OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CNT_WIDTH-1:0]   num_q, num_d;
  logic [CNT_WIDTH-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [PTR_W:0]         occ_q, occ_d;

  logic [MEM_BW-1:0]      fifo_mem [FIFO_DEPTH];

  logic run;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // All outputs decode registered state only, so no input reaches an output combinationally.
  assign run        = (state_q == S_RUN);
  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);

  assign in_ready  = run && !fifo_full && (acc_cnt_q < num_q);
  assign mem_we    = run && !fifo_empty;
  assign mem_addr  = base_q + ADDR_WIDTH'(wr_cnt_q);
  assign mem_wdata = mem_we ? fifo_mem[rptr_q] : '0;
  assign busy      = run;
  assign done      = (state_q == S_DONE);

  assign push = in_valid && in_ready;
  assign pop  = mem_we && mem_gnt;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          num_d     = num_words;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = (num_words == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (push) begin
          acc_cnt_d = acc_cnt_q + CNT_ONE;
        end
        if (pop) begin
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          if ((wr_cnt_q + CNT_ONE) == num_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      num_q     <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      num_q     <= num_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
    end
  end

`ifdef OUTPUT_WRITER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where a write request waits for its grant.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start) begin
      stall_d = '0;
    end else if (mem_we && !mem_gnt && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_output_writer.sv
// Scoreboard bench for output_writer: stimulus queues expected SRAM writes, a monitor pops and compares them.
module tb_output_writer;

  localparam int MEM_BW = 128;
  localparam int AW     = 16;
  localparam int CW     = 16;

  logic              clk       = 1'b0;
  logic              arst      = 1'b1;
  logic              start     = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [CW-1:0]     num_words = '0;
  logic [MEM_BW-1:0] in_data   = '0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [MEM_BW-1:0] mem_wdata;
  logic              mem_gnt   = 1'b0;
  logic              busy;
  logic              done;
`ifdef OUTPUT_WRITER_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  output_writer #(
    .MEM_BW(MEM_BW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .busy(busy), .done(done)
`ifdef OUTPUT_WRITER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [MEM_BW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [MEM_BW-1:0] word_of(input logic [7:0] job, input logic [7:0] idx);
    return {job, idx, 112'h0102030405060708090A0B0C0D0E};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [AW-1:0] a, input logic [MEM_BW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every granted write against the scoreboard and checks stall stability.
  logic              mon_stall_prev = 1'b0;
  logic [AW-1:0]     mon_pa;
  logic [MEM_BW-1:0] mon_pd;
  wr_t               mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_stall_prev) begin
        chk("hold_we", 128'(mem_we), 128'(1));
        chk("hold_addr", 128'(mem_addr), 128'(mon_pa));
        chk("hold_data", mem_wdata, mon_pd);
      end
      mon_stall_prev = mem_we && !mem_gnt;
      mon_pa = mem_addr;
      mon_pd = mem_wdata;
      if (mem_we && mem_gnt) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got write to addr %h, required no write", mem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 128'(mem_addr), 128'(mon_e.addr));
          chk("wr_data", mem_wdata, mon_e.data);
          $display("[TB] write addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [7:0] job,
                         input int n_offer, input int stall_n, input int glitch_at,
                         output int accepts, output int drop_acc, output int last_g,
                         output int done_at, output bit saw_we, output bit saw_ready);
    int c  = 0;
    int i  = 0;
    int st = 0;
    bit a;
    bit fin = 1'b0;
    drop_acc  = -1;
    last_g    = -1;
    done_at   = -1;
    saw_we    = 1'b0;
    saw_ready = 1'b0;
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    in_valid  = (n_offer > 0);
    in_data   = word_of(job, 8'd0);
    mem_gnt   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!fin && c < 300) begin
      @(negedge clk);
      if (mem_we)   saw_we = 1'b1;
      if (in_ready) saw_ready = 1'b1;
      if (done) begin
        done_at = c;
        fin = 1'b1;
        chk("busy_at_done", 128'(busy), 128'(0));
      end else begin
        if (drop_acc < 0 && busy && !in_ready) drop_acc = i;
        a = in_valid && in_ready;
        if (mem_we && mem_gnt) last_g = c;
        @(posedge clk); #1;
        if (a) begin
          i++;
          in_valid = (i < n_offer);
          in_data  = word_of(job, 8'(i));
        end
        if (mem_we && st < stall_n) begin
          mem_gnt = 1'b0;
          st++;
        end else begin
          mem_gnt = 1'b1;
        end
        if (c == glitch_at) begin
          start     = 1'b1;
          base_addr = 16'h0AAA;
          num_words = 16'd2;
        end else begin
          start = 1'b0;
        end
        c++;
      end
    end
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_timeout: got no done after %0d cycles, required done", c);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    accepts  = i;
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("busy_after_done", 128'(busy), 128'(0));
    @(posedge clk); #1;
  endtask

  int acc, drop, lg, dat, grants, ri;
  bit swe, srdy, ra;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    @(posedge clk); #1;
    arst = 1'b0;
    @(posedge clk); #1;

    // Basic job
    for (int k = 0; k < 4; k++) exp_push(16'h0100 + 16'(k), word_of(8'd1, 8'(k)));
    run_job(16'h0100, 16'd4, 8'd1, 4, 0, -1, acc, drop, lg, dat, swe, srdy);
    chk("basic_accepts", 128'(acc), 128'(4));
    chk("basic_drop_acc", 128'(drop), 128'(4));
    chk("basic_last_grant", 128'(lg), 128'(4));
    chk("basic_done_at", 128'(dat), 128'(5));
`ifdef OUTPUT_WRITER_STALL_CNT_EN
    chk("basic_stall", 128'(stall_cycles), 128'(0));
`endif

    // Backpressure: ten stalled grant cycles
    for (int k = 0; k < 8; k++) exp_push(16'h0040 + 16'(k), word_of(8'd2, 8'(k)));
    run_job(16'h0040, 16'd8, 8'd2, 8, 10, -1, acc, drop, lg, dat, swe, srdy);
    chk("bp_accepts", 128'(acc), 128'(8));
    chk("bp_drop_acc", 128'(drop), 128'(4));
    chk("bp_last_grant", 128'(lg), 128'(18));
    chk("bp_done_at", 128'(dat), 128'(19));
`ifdef OUTPUT_WRITER_STALL_CNT_EN
    chk("bp_stall", 128'(stall_cycles), 128'(10));
`endif

    // Zero-length job
    run_job(16'h0500, 16'd0, 8'd3, 2, 0, -1, acc, drop, lg, dat, swe, srdy);
    chk("zero_done_at", 128'(dat), 128'(0));
    chk("zero_no_we", 128'(swe), 128'(0));
    chk("zero_no_ready", 128'(srdy), 128'(0));
    chk("zero_accepts", 128'(acc), 128'(0));

    // Address wrap with excess input words
    exp_push(16'hFFFE, word_of(8'd4, 8'd0));
    exp_push(16'hFFFF, word_of(8'd4, 8'd1));
    exp_push(16'h0000, word_of(8'd4, 8'd2));
    run_job(16'hFFFE, 16'd3, 8'd4, 5, 0, -1, acc, drop, lg, dat, swe, srdy);
    chk("wrap_accepts", 128'(acc), 128'(3));
    chk("wrap_drop_acc", 128'(drop), 128'(3));
    chk("wrap_done_at", 128'(dat), 128'(4));

    // Second start during RUN must be ignored
    for (int k = 0; k < 5; k++) exp_push(16'h0300 + 16'(k), word_of(8'd5, 8'(k)));
    run_job(16'h0300, 16'd5, 8'd5, 5, 0, 2, acc, drop, lg, dat, swe, srdy);
    chk("busy_start_accepts", 128'(acc), 128'(5));
    chk("busy_start_last_grant", 128'(lg), 128'(5));
    chk("busy_start_done_at", 128'(dat), 128'(6));

    // Reset in the middle of a job
    for (int k = 0; k < 6; k++) exp_push(16'h0200 + 16'(k), word_of(8'd6, 8'(k)));
    base_addr = 16'h0200;
    num_words = 16'd6;
    start     = 1'b1;
    in_valid  = 1'b1;
    in_data   = word_of(8'd6, 8'd0);
    mem_gnt   = 1'b1;
    grants    = 0;
    ri        = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && grants < 2; c++) begin
      @(negedge clk);
      ra = in_valid && in_ready;
      if (mem_we && mem_gnt) grants++;
      @(posedge clk); #1;
      if (ra) begin
        ri++;
        in_data = word_of(8'd6, 8'(ri));
      end
    end
    chk("mid_grants", 128'(grants), 128'(2));
    arst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_in_ready", 128'(in_ready), 128'(0));
    chk("mid_mem_we", 128'(mem_we), 128'(0));
    chk("mid_mem_addr", 128'(mem_addr), 128'(0));
    chk("mid_mem_wdata", mem_wdata, 128'(0));
    chk("mid_busy", 128'(busy), 128'(0));
    chk("mid_done", 128'(done), 128'(0));
    @(posedge clk); #1;
    arst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_we", 128'(mem_we), 128'(0));
      chk("post_rst_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_push(16'h0010, word_of(8'd7, 8'd0));
    run_job(16'h0010, 16'd1, 8'd7, 1, 0, -1, acc, drop, lg, dat, swe, srdy);
    chk("after_rst_accepts", 128'(acc), 128'(1));
    chk("after_rst_last_grant", 128'(lg), 128'(1));
    chk("after_rst_done_at", 128'(dat), 128'(2));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
